// File: rtl/reg_alu_pipe_if.sv
// Instruction issue, register file and retire signals of reg_alu_pipe.
// Latency: none, wires only.
// Backpressure: in_ready carries the pipeline stall back to the issuer.
interface reg_alu_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [7:0]  in_rd;
   logic [7:0]  in_rs1;
   logic [7:0]  in_rs2;
   logic [31:0] in_imm;
   logic        stall;
   logic [7:0]  addr_a;
   logic [7:0]  addr_b;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        we;
   logic [7:0]  addr_wr;
   logic [31:0] data_in;
   logic        retire_valid;
   logic [7:0]  retire_rd;
   logic [31:0] retire_data;
   logic [31:0] retired_count;

   // Issuer / register file side.
   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, stall, data_a, data_b,
      input  in_ready, addr_a, addr_b, we, addr_wr, data_in,
             retire_valid, retire_rd, retire_data, retired_count
   );

   // Pipeline side.
   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, stall, data_a, data_b,
      output in_ready, addr_a, addr_b, we, addr_wr, data_in,
             retire_valid, retire_rd, retire_data, retired_count
   );
endinterface

// File: rtl/reg_alu_pipe.sv
// Issue/execute/writeback ALU pipeline with S2/S3 forwarding in front of a 2R1W register file.
// Latency: register file written two edges after the instruction is accepted.
// Backpressure: stall freezes S1/S2, drops in_ready, blocks writes and re-reads S1 sources.
module reg_alu_pipe (
   input logic           clk,
   input logic           rst_n,
   reg_alu_pipe_if.slave bus
);
   typedef struct packed {
      logic        valid;
      logic [3:0]  op;
      logic [7:0]  rd;
      logic [7:0]  rs1;
      logic [7:0]  rs2;
      logic [31:0] imm;
   } exe_t;

   typedef struct packed {
      logic        valid;
      logic [7:0]  rd;
      logic [31:0] result;
   } wb_t;

   exe_t        s1;
   wb_t         s2;
   wb_t         s3;
   logic [31:0] count;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] alu_res;

   assign bus.in_ready = !bus.stall;

   // While stalled the register file must keep returning the held S1 sources.
   assign bus.addr_a = bus.stall ? s1.rs1 : bus.in_rs1;
   assign bus.addr_b = bus.stall ? s1.rs2 : bus.in_rs2;

   // Operand A: r0, then youngest in-flight result, then last committed write, then register file.
   always_comb begin
      if (s1.rs1 == 8'd0)                         opa = 32'd0;
      else if (s2.valid && (s2.rd == s1.rs1))     opa = s2.result;
      else if (s3.valid && (s3.rd == s1.rs1))     opa = s3.result;
      else                                        opa = bus.data_a;
   end

   // Operand B: same priority as A on the second source.
   always_comb begin
      if (s1.rs2 == 8'd0)                         opb = 32'd0;
      else if (s2.valid && (s2.rd == s1.rs2))     opb = s2.result;
      else if (s3.valid && (s3.rd == s1.rs2))     opb = s3.result;
      else                                        opb = bus.data_b;
   end

   // ALU; opcodes 12-15 produce nothing and are filtered out of S2.valid.
   always_comb begin
      alu_res = 32'd0;
      case (s1.op)
         4'd0:    alu_res = opa + opb;
         4'd1:    alu_res = opa - opb;
         4'd2:    alu_res = opa & opb;
         4'd3:    alu_res = opa | opb;
         4'd4:    alu_res = opa ^ opb;
         4'd5:    alu_res = opa << opb[4:0];
         4'd6:    alu_res = opa >> opb[4:0];
         4'd7:    alu_res = $unsigned($signed(opa) >>> opb[4:0]);
         4'd8:    alu_res = {31'd0, ($signed(opa) < $signed(opb))};
         4'd9:    alu_res = {31'd0, (opa < opb)};
         4'd10:   alu_res = opa + s1.imm;
         4'd11:   alu_res = s1.imm;
         default: alu_res = 32'd0;
      endcase
   end

   // Stage advance; a stall holds S1/S2 and invalidates S3 since the re-read sees committed data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1    <= '0;
         s2    <= '0;
         s3    <= '0;
         count <= 32'd0;
      end else if (bus.stall) begin
         s3.valid <= 1'b0;
      end else begin
         s1.valid  <= bus.in_valid;
         s1.op     <= bus.in_op;
         s1.rd     <= bus.in_rd;
         s1.rs1    <= bus.in_rs1;
         s1.rs2    <= bus.in_rs2;
         s1.imm    <= bus.in_imm;
         s2.valid  <= s1.valid && (s1.op < 4'd12);
         s2.rd     <= s1.rd;
         s2.result <= alu_res;
         s3        <= s2;
         if (s2.valid) begin
            count <= count + 32'd1;
         end
      end
   end

   // Reset gates the write combinationally so a pending S2 write is dropped at the reset edge.
   assign bus.we            = rst_n && s2.valid && (s2.rd != 8'd0) && !bus.stall;
   assign bus.addr_wr       = s2.rd;
   assign bus.data_in       = s2.result;
   assign bus.retire_valid  = rst_n && s2.valid && !bus.stall;
   assign bus.retire_rd     = s2.rd;
   assign bus.retire_data   = s2.result;
   assign bus.retired_count = count;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Bench for reg_alu_pipe: register file model, directed sequences, vector table, random run.
// Latency: n/a.
// Backpressure: stall driven directly by the bench.
module tb_reg_alu_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_alu_pipe_if bus();
   reg_alu_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct {
      int          cyc;
      logic        we;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic [7:0]  rd;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      logic [7:0]  rd;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic        wr;
      logic [31:0] res;
   } vec_t;

   logic [31:0] rf [256] = '{default: 32'd0};
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          spurious_we = 0;
   ev_t         ret_q[$];
   exp_t        exp_q[$];
   logic [31:0] arch [8];
   vec_t        vecs [14];

   // Register file: registered read of the presented address, write at the edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.data_a <= rf[bus.addr_a];
      bus.data_b <= rf[bus.addr_b];
      if (bus.we) rf[bus.addr_wr] <= bus.data_in;
   end

   // Retire monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.retire_valid)
         ret_q.push_back('{cyc, bus.we, bus.addr_wr, bus.data_in, bus.retire_rd, bus.retire_data});
      if (bus.we && !bus.retire_valid) spurious_we++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] rd, input logic [7:0] rs1,
                        input logic [7:0] rs2, input logic [31:0] imm);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      bus.in_imm   = imm;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
      logic [63:0] ext;
      int          sh;
      sh = int'(b % 32);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a * (32'd1 << sh);
         4'd6:  return a / (32'd1 << sh);
         4'd7: begin
            ext = {{32{a[31]}}, a};
            ext = ext >> sh;
            return ext[31:0];
         end
         4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: return a + imm;
         4'd11: return imm;
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      logic        st, vl;
      logic [3:0]  op;
      logic [7:0]  rd, rs1, rs2;
      logic [31:0] imm, res;
      int          n;

      vecs[0]  = '{4'd0,  32'd5,        32'd7,        32'd0,          1'b1, 32'd12};
      vecs[1]  = '{4'd1,  32'd5,        32'd7,        32'd0,          1'b1, 32'hFFFF_FFFE};
      vecs[2]  = '{4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'd0,        1'b1, 32'h0000_F000};
      vecs[3]  = '{4'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'd0,        1'b1, 32'h0000_FFF0};
      vecs[4]  = '{4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'd0,        1'b1, 32'h0000_0FF0};
      vecs[5]  = '{4'd5,  32'd1,        32'd35,       32'd0,          1'b1, 32'd8};
      vecs[6]  = '{4'd6,  32'h8000_0000, 32'd31,      32'd0,          1'b1, 32'd1};
      vecs[7]  = '{4'd7,  32'h8000_0000, 32'd4,       32'd0,          1'b1, 32'hF800_0000};
      vecs[8]  = '{4'd8,  32'hFFFF_FFFF, 32'd1,       32'd0,          1'b1, 32'd1};
      vecs[9]  = '{4'd9,  32'hFFFF_FFFF, 32'd1,       32'd0,          1'b1, 32'd0};
      vecs[10] = '{4'd10, 32'h7FFF_FFFF, 32'd9,       32'd1,          1'b1, 32'h8000_0000};
      vecs[11] = '{4'd11, 32'd3,        32'd4,        32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF};
      vecs[12] = '{4'd0,  32'hFFFF_FFFF, 32'd2,       32'd0,          1'b1, 32'd1};
      vecs[13] = '{4'd13, 32'd3,        32'd4,        32'd0,          1'b0, 32'd0};

      bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_rd = 8'd0; bus.in_rs1 = 8'd0;
      bus.in_rs2 = 8'd0; bus.in_imm = 32'd0; bus.stall = 1'b0;
      do_reset();

      // Reset state and combinational outputs.
      bus.in_rs1 = 8'd3; bus.in_rs2 = 8'd5;
      @(negedge clk);
      check("rst_we", bus.we, 1'b0);
      check("rst_retire_valid", bus.retire_valid, 1'b0);
      check("rst_count", bus.retired_count, 32'd0);
      check("rst_retire_rd", bus.retire_rd, 8'd0);
      check("rst_retire_data", bus.retire_data, 32'd0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_addr_a", bus.addr_a, 8'd3);
      check("rst_addr_b", bus.addr_b, 8'd5);
      @(posedge clk); #1;

      // LI r1,5; LI r2,7; ADD r3,r1,r2
      ret_q.delete();
      issue(4'd11, 8'd1, 8'd0, 8'd0, 32'd5);
      issue(4'd11, 8'd2, 8'd0, 8'd0, 32'd7);
      issue(4'd0, 8'd3, 8'd1, 8'd2, 32'd0);
      idle(3);
      check("t1_retires", ret_q.size(), 3);
      if (ret_q.size() == 3) begin
         check("t1_rd", ret_q[2].rd, 8'd3);
         check("t1_data", ret_q[2].data, 32'd12);
      end
      check("t1_rf3", rf[3], 32'd12);
      check("t1_count", bus.retired_count, 32'd3);

      // Dependency chain through S2 and S3 forwarding.
      ret_q.delete();
      issue(4'd11, 8'd1, 8'd0, 8'd0, 32'd1);
      repeat (4) issue(4'd10, 8'd1, 8'd1, 8'd0, 32'd1);
      idle(3);
      check("chain_retires", ret_q.size(), 5);
      n = ret_q.size();
      for (int i = 0; i < n && i < 5; i++) begin
         check($sformatf("chain_data%0d", i), ret_q[i].data, 32'(i + 1));
         check($sformatf("chain_cyc%0d", i), 32'(ret_q[i].cyc - ret_q[0].cyc), 32'(i));
      end
      check("chain_rf1", rf[1], 32'd5);

      // r0 is never written and always reads zero.
      ret_q.delete();
      issue(4'd11, 8'd4, 8'd0, 8'd0, 32'h77);
      issue(4'd11, 8'd0, 8'd0, 8'd0, 32'hFFFF);
      issue(4'd0, 8'd4, 8'd0, 8'd0, 32'd0);
      idle(3);
      check("r0_retires", ret_q.size(), 3);
      if (ret_q.size() == 3) begin
         check("r0_we_li", ret_q[1].we, 1'b0);
         check("r0_we_add", ret_q[2].we, 1'b1);
         check("r0_add_data", ret_q[2].data, 32'd0);
      end
      check("r0_rf0", rf[0], 32'd0);
      check("r0_rf4", rf[4], 32'd0);

      // Shifts and compares on a negative operand.
      issue(4'd11, 8'd7, 8'd0, 8'd0, 32'd4);
      issue(4'd10, 8'd5, 8'd0, 8'd0, 32'hFFFF_FFFF);
      issue(4'd7, 8'd6, 8'd5, 8'd7, 32'd0);
      issue(4'd6, 8'd8, 8'd5, 8'd7, 32'd0);
      issue(4'd8, 8'd9, 8'd5, 8'd0, 32'd0);
      issue(4'd9, 8'd10, 8'd5, 8'd0, 32'd0);
      idle(3);
      check("sh_rf6", rf[6], 32'hFFFF_FFFF);
      check("sh_rf8", rf[8], 32'h0FFF_FFFF);
      check("sh_rf9", rf[9], 32'd1);
      check("sh_rf10", rf[10], 32'd0);

      // Stall for 3 cycles with the dependent ADD in S1.
      ret_q.delete();
      issue(4'd11, 8'd1, 8'd0, 8'd0, 32'd9);
      issue(4'd0, 8'd2, 8'd1, 8'd1, 32'd0);
      bus.stall = 1'b1; bus.in_rs1 = 8'd9; bus.in_rs2 = 8'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("stall_ready%0d", i), bus.in_ready, 1'b0);
         check($sformatf("stall_we%0d", i), bus.we, 1'b0);
         check($sformatf("stall_addr_a%0d", i), bus.addr_a, 8'd1);
         @(posedge clk); #1;
      end
      bus.stall = 1'b0;
      idle(3);
      check("stall_retires", ret_q.size(), 2);
      if (ret_q.size() == 2) check("stall_add_data", ret_q[1].data, 32'd18);
      check("stall_rf2", rf[2], 32'd18);

      // Opcode table: LI r1,a; LI r2,b; OP r3,r1,r2,imm.
      for (int i = 0; i < 14; i++) begin
         ret_q.delete();
         issue(4'd11, 8'd1, 8'd0, 8'd0, vecs[i].a);
         issue(4'd11, 8'd2, 8'd0, 8'd0, vecs[i].b);
         issue(vecs[i].op, 8'd3, 8'd1, 8'd2, vecs[i].imm);
         idle(3);
         check($sformatf("vec%0d_retires", i), ret_q.size(), 32'd2 + 32'(vecs[i].wr));
         if (vecs[i].wr && ret_q.size() == 3)
            check($sformatf("vec%0d_result", i), ret_q[2].data, vecs[i].res);
      end

      // Reset while an instruction sits in S2.
      ret_q.delete();
      issue(4'd11, 8'd11, 8'd0, 8'd0, 32'h55);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_we", bus.we, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_count", bus.retired_count, 32'd0);
      check("mid_rst_retires", ret_q.size(), 0);
      check("mid_rst_rf11", rf[11], 32'd0);
      @(posedge clk); #1;
      issue(4'd11, 8'd12, 8'd0, 8'd0, 32'h33);
      idle(3);
      check("mid_rst_rf12", rf[12], 32'h33);
      check("mid_rst_count2", bus.retired_count, 32'd1);

      // Randomized run against the sequential architectural model.
      do_reset();
      ret_q.delete();
      exp_q.delete();
      spurious_we = 0;
      for (int i = 0; i < 8; i++) arch[i] = 32'd0;
      for (int c = 0; c < 600; c++) begin
         st  = (c >= 7) && ($urandom_range(0, 4) == 0);
         vl  = (c < 7) || ($urandom_range(0, 3) != 0);
         op  = (c < 7) ? 4'd11 : 4'($urandom_range(0, 15));
         rd  = (c < 7) ? 8'(c + 1) : 8'($urandom_range(0, 7));
         rs1 = 8'($urandom_range(0, 7));
         rs2 = 8'($urandom_range(0, 7));
         imm = $urandom;
         bus.stall = st; bus.in_valid = vl; bus.in_op = op; bus.in_rd = rd;
         bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
         @(negedge clk);
         check("rnd_in_ready", bus.in_ready, !st);
         if (vl && !st) begin
            res = ref_alu(op, arch[rs1[2:0]], arch[rs2[2:0]], imm);
            if (op < 4'd12) begin
               exp_q.push_back('{rd, res});
               if (rd != 8'd0) arch[rd[2:0]] = res;
            end
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0; bus.stall = 1'b0;
      idle(4);
      check("rnd_retires", ret_q.size(), exp_q.size());
      n = (ret_q.size() < exp_q.size()) ? ret_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("rnd_rd%0d", i), ret_q[i].rd, exp_q[i].rd);
         check($sformatf("rnd_data%0d", i), ret_q[i].data, exp_q[i].data);
         check($sformatf("rnd_we%0d", i), ret_q[i].we, exp_q[i].rd != 8'd0);
         check($sformatf("rnd_wa%0d", i), ret_q[i].wa, exp_q[i].rd);
         check($sformatf("rnd_wd%0d", i), ret_q[i].wd, exp_q[i].data);
      end
      for (int i = 1; i < 8; i++) check($sformatf("rnd_rf%0d", i), rf[i], arch[i]);
      check("rnd_count", bus.retired_count, exp_q.size());
      check("rnd_spurious_we", spurious_we, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
